mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 The instruction-fetch port SHALL be: if_req  in  1  fetch request, held until if_done; if_addr  in  32  fetch address; if_rdata  out  32  fetched word; if_done  out  1  one-cycle completion pulse.
REQ-003 The data port SHALL be: mem_req  in  1  data request, held until mem_done; mem_we  in  1  1=store, 0=load; mem_addr  in  32  data address; mem_wdata  in  32  store data; mem_sel  in  4  byte enables; mem_rdata  out  32  load data; mem_done  out  1  one-cycle completion pulse.
REQ-004 The external memory port SHALL be: ext_req  out  1  transaction valid; ext_we  out  1  write; ext_addr  out  32  address; ext_wdata  out  32  write data; ext_sel  out  4  byte enables; ext_ack  in  1  completion; ext_rdata  in  32  read data.
REQ-005 The pipeline stall outputs SHALL be: stall_if  out  1  = if_req & ~if_done; stall_mem  out  1  = mem_req & ~mem_done.

Function
REQ-006 The FSM SHALL have the states IDLE, BUSY_IF, BUSY_MEM and DONE, and every ext_*, *_done and *_rdata output SHALL be registered.
REQ-007 Requests SHALL be sampled only in IDLE; in IDLE with mem_req=1 the FSM SHALL move to BUSY_MEM, otherwise with if_req=1 to BUSY_IF, otherwise it SHALL stay in IDLE.
REQ-008 On a grant edge the block SHALL latch the address, we, wdata and sel of the granted port onto ext_*, and ext_req SHALL be 1 from the following cycle.
REQ-009 A fetch SHALL drive ext_we=0, ext_sel=4'b1111 and ext_wdata=0.
REQ-010 In a BUSY state, ext_* SHALL hold stable until ext_ack=1 is sampled.
REQ-011 On the edge where ext_ack=1 is sampled, the block SHALL clear ext_req, capture ext_rdata into the granted port's rdata (also for stores, where the value is don't-care), and enter DONE.
REQ-012 In DONE the granted port's done output SHALL be 1 for exactly one cycle, no grant SHALL be made, and the FSM SHALL return to IDLE on the next edge.
REQ-013 A request still asserted in the IDLE cycle after DONE SHALL be treated as a new request.
REQ-014 The minimum latency SHALL be: request sampled in IDLE at cycle 0, ext_req in cycle 1, ext_ack in cycle 1, done in cycle 2, next grant decision in cycle 3.
REQ-015 rdata outputs SHALL hold their last captured value until the next completion for that port.
REQ-016 ext_ack SHALL be ignored in IDLE and DONE.
REQ-017 If if_req and mem_req rise in the same IDLE cycle, mem SHALL win, subject to REQ-021.
REQ-018 Addresses SHALL pass through unmodified; the block SHALL perform no alignment check.

Reset
REQ-019 When rst=1 is sampled, the block SHALL enter IDLE with all outputs 0: ext_req, ext_we, ext_addr, ext_wdata, ext_sel, if_done, mem_done, if_rdata and mem_rdata; any starvation counter SHALL also reset to 0.
REQ-020 A reset asserted mid-transaction SHALL abandon that transaction with no done pulse, and an ext_ack arriving after reset SHALL be ignored.

Configuration
REQ-021 With the macro MEM_ARB_STARVE_GUARD_EN defined, the block SHALL behave as follows.
- It SHALL keep a 3-bit count of consecutive mem grants made while if_req=1.
- When the count reaches 4, the next IDLE arbitration with if_req=1 SHALL grant fetch, even if mem_req=1.
- Any fetch grant SHALL clear the count.
REQ-022 Without MEM_ARB_STARVE_GUARD_EN, mem SHALL have strict priority, no counter logic SHALL exist, and the port list SHALL be identical to the with-macro build.

Verification
REQ-023 The bench SHALL cover a single fetch: if_req=1, if_addr=0x100, ext_ack after 2 cycles with ext_rdata=0x00000013 -> ext_addr=0x100, ext_we=0, ext_sel=4'hF, if_done pulses once, if_rdata=0x00000013.
REQ-024 The bench SHALL cover a simultaneous request: if_req=1 and mem_req=1 (store, mem_addr=0x2000, mem_wdata=0xDEADBEEF, mem_sel=4'h3) in the same cycle -> store granted first, fetch granted in the IDLE cycle after mem_done, stall_if=1 throughout until if_done.
REQ-025 The bench SHALL cover zero-wait memory: ext_ack tied 1 with back-to-back fetches -> one grant every 3 cycles, done spacing 3 cycles.
REQ-026 The bench SHALL cover reset mid-access: rst asserted while in BUSY_MEM -> ext_req=0 and mem_done=0 on the next edge, no done pulse, and a subsequent ext_ack is ignored.
REQ-027 The bench SHALL cover starvation: mem_req held continuously with if_req=1 -> with MEM_ARB_STARVE_GUARD_EN, the 5th grant goes to fetch; without the macro, fetch is never granted while mem_req=1.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- bundles the three buses around the memory arbiter.
//
//   Fetch port : if_req, if_addr           -> arbiter
//                if_rdata, if_done         <- arbiter
//   Data port  : mem_req, mem_we, mem_addr,
//                mem_wdata, mem_sel        -> arbiter
//                mem_rdata, mem_done       <- arbiter
//   External   : ext_req, ext_we, ext_addr,
//                ext_wdata, ext_sel        <- arbiter
//                ext_ack, ext_rdata        -> arbiter
//   Stalls     : stall_if, stall_mem       <- arbiter
//
// Handshake: a requester raises *_req and holds it, with stable attributes,
// until it sees the one-cycle *_done pulse. Towards memory, ext_req is the
// valid and ext_ack the one-cycle ready/completion; ext_* stay stable while
// ext_req=1 and ext_rdata is taken on the ack cycle.
//
// The arbiter connects through the slave modport; the pipeline/memory side
// (or a testbench) uses master.

interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_sel;
    logic [31:0] mem_rdata;
    logic        mem_done;

    logic        ext_req;
    logic        ext_we;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic [3:0]  ext_sel;
    logic        ext_ack;
    logic [31:0] ext_rdata;

    logic        stall_if;
    logic        stall_mem;

    modport slave (
        input  if_req, if_addr,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_sel,
        input  ext_ack, ext_rdata,
        output if_rdata, if_done,
        output mem_rdata, mem_done,
        output ext_req, ext_we, ext_addr, ext_wdata, ext_sel,
        output stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_sel,
        output ext_ack, ext_rdata,
        input  if_rdata, if_done,
        input  mem_rdata, mem_done,
        input  ext_req, ext_we, ext_addr, ext_wdata, ext_sel,
        input  stall_if, stall_mem
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one external memory bus between an instruction-fetch
// port and a data port. One transaction at a time, mem has priority.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   bus        mem_arbiter_if.slave (fetch, data, external, stall signals)
//   dbg_state  current FSM state (IDLE=0, BUSY_IF=1, BUSY_MEM=2, DONE=3)
//
// Sequence: IDLE samples requests and latches the winner onto ext_*; BUSY_*
// holds ext_* until ext_ack; the ack edge captures ext_rdata and raises the
// granted done; DONE lasts one cycle and returns to IDLE. Minimum turnaround
// is therefore 3 cycles per transaction.
//
// Optional feature macro: MEM_ARB_STARVE_GUARD_EN. When defined, after four
// consecutive mem grants made while a fetch was waiting, the next IDLE
// arbitration with if_req=1 goes to fetch. When undefined, mem has strict
// priority and no counter exists. Ports are the same in both builds.

module mem_arbiter (
    input  logic               clk,
    input  logic               rst,
    mem_arbiter_if.slave       bus,
    output logic [1:0]         dbg_state
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] BUSY_IF  = 2'd1;
    localparam logic [1:0] BUSY_MEM = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    logic [1:0] state;
    logic       grant_mem;
    logic       grant_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [2:0] starve_cnt;
    logic       force_if;

    // Guard trips once four mem grants have gone by with a fetch waiting.
    assign force_if  = bus.if_req && (starve_cnt == 3'd4);
    assign grant_mem = bus.mem_req && !force_if;

    // Only grants made in IDLE move the counter. A mem grant with no fetch
    // waiting breaks the run of consecutive starving grants.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 3'd0;
        end else if (state == IDLE) begin
            if (grant_mem) begin
                if (!bus.if_req)
                    starve_cnt <= 3'd0;
                else if (starve_cnt != 3'd4)
                    starve_cnt <= starve_cnt + 3'd1;
            end else if (grant_if) begin
                starve_cnt <= 3'd0;
            end
        end
    end
`else
    assign grant_mem = bus.mem_req;
`endif

    assign grant_if = bus.if_req && !grant_mem;

    assign bus.stall_if  = bus.if_req  & ~bus.if_done;
    assign bus.stall_mem = bus.mem_req & ~bus.mem_done;
    assign dbg_state     = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.ext_req   <= 1'b0;
            bus.ext_we    <= 1'b0;
            bus.ext_addr  <= 32'd0;
            bus.ext_wdata <= 32'd0;
            bus.ext_sel   <= 4'd0;
            bus.if_done   <= 1'b0;
            bus.mem_done  <= 1'b0;
            bus.if_rdata  <= 32'd0;
            bus.mem_rdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_mem) begin
                        state         <= BUSY_MEM;
                        bus.ext_req   <= 1'b1;
                        bus.ext_we    <= bus.mem_we;
                        bus.ext_addr  <= bus.mem_addr;
                        bus.ext_wdata <= bus.mem_wdata;
                        bus.ext_sel   <= bus.mem_sel;
                    end else if (grant_if) begin
                        // Fetches are always full-word reads.
                        state         <= BUSY_IF;
                        bus.ext_req   <= 1'b1;
                        bus.ext_we    <= 1'b0;
                        bus.ext_addr  <= bus.if_addr;
                        bus.ext_wdata <= 32'd0;
                        bus.ext_sel   <= 4'b1111;
                    end
                end
                BUSY_IF, BUSY_MEM: begin
                    if (bus.ext_ack) begin
                        bus.ext_req <= 1'b0;
                        state       <= DONE;
                        // rdata is captured for stores too; the value is unused.
                        if (state == BUSY_MEM) begin
                            bus.mem_rdata <= bus.ext_rdata;
                            bus.mem_done  <= 1'b1;
                        end else begin
                            bus.if_rdata  <= bus.ext_rdata;
                            bus.if_done   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    bus.if_done  <= 1'b0;
                    bus.mem_done <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
